// File: rtl/mem_arbiter.sv
`timescale 1ns/1ps
// mem_arbiter: cpu/dbg arbiter in front of one synchronous single-port RAM.
// Round-robin between the ports, with a lockable dbg burst of up to MAX_BURST grants.
module mem_arbiter #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W:0]   cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W:0]   dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  input  logic              dbg_lock,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_we,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int CNT_W = $clog2(MAX_BURST + 1);

  typedef enum logic {RR, DBG_BURST} state_e;

  state_e            state_q, state_d;
  logic              ptr_q, ptr_d;  // 1: dbg wins the next tie
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic              cpu_rv_q, dbg_rv_q, oor_q;
  logic [DATA_W-1:0] cpu_rdata_q, dbg_rdata_q;
  logic [DATA_W-1:0] rd_val;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RR;
      ptr_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (cpu_gnt) ptr_d = 1'b1;
    if (dbg_gnt) ptr_d = 1'b0;
    case (state_q)
      RR: begin
        if (dbg_gnt && dbg_lock && (MAX_BURST > 1)) begin
          state_d = DBG_BURST;
          cnt_d   = CNT_W'(1);
        end
      end
      DBG_BURST: begin
        if (!dbg_lock || (dbg_gnt && (cnt_q == CNT_W'(MAX_BURST - 1)))) begin
          state_d = RR;
          cnt_d   = '0;
          ptr_d   = 1'b0;
        end else if (dbg_gnt) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
  end

  always_comb begin : outputs
    cpu_gnt = 1'b0;
    dbg_gnt = 1'b0;
    if (!reset) begin
      case (state_q)
        RR: begin
          if (cpu_req && (!dbg_req || !ptr_q)) cpu_gnt = 1'b1;
          else if (dbg_req)                    dbg_gnt = 1'b1;
        end
        DBG_BURST: dbg_gnt = dbg_req;
      endcase
    end

    ram_addr  = addr_q;
    ram_we    = 1'b0;
    ram_wdata = '0;
    if (cpu_gnt) begin
      ram_addr  = cpu_addr[ADDR_W-1:0];
      ram_we    = cpu_we & ~cpu_addr[ADDR_W];
      ram_wdata = cpu_wdata;
    end else if (dbg_gnt) begin
      ram_addr  = dbg_addr[ADDR_W-1:0];
      ram_we    = dbg_we & ~dbg_addr[ADDR_W];
      ram_wdata = dbg_wdata;
    end
    if (reset) ram_addr = '0;

    // Read data passes straight from the RAM in the rvalid cycle, then is held.
    rd_val     = oor_q ? '0 : ram_rdata;
    cpu_rvalid = cpu_rv_q & ~reset;
    dbg_rvalid = dbg_rv_q & ~reset;
    cpu_rdata  = reset ? '0 : (cpu_rv_q ? rd_val : cpu_rdata_q);
    dbg_rdata  = reset ? '0 : (dbg_rv_q ? rd_val : dbg_rdata_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q      <= '0;
      cpu_rv_q    <= 1'b0;
      dbg_rv_q    <= 1'b0;
      oor_q       <= 1'b0;
      cpu_rdata_q <= '0;
      dbg_rdata_q <= '0;
    end else begin
      addr_q      <= ram_addr;
      cpu_rv_q    <= cpu_gnt & ~cpu_we;
      dbg_rv_q    <= dbg_gnt & ~dbg_we;
      oor_q       <= cpu_gnt ? cpu_addr[ADDR_W] : dbg_addr[ADDR_W];
      cpu_rdata_q <= cpu_rdata;
      dbg_rdata_q <= dbg_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
// tb_mem_arbiter: vector table plus directed burst/reset sequences; read returns are
// checked against a shadow memory through an expectation queue.
module tb_mem_arbiter;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_req, cpu_we, cpu_gnt, cpu_rvalid;
  logic [AW:0]   cpu_addr;
  logic [DW-1:0] cpu_wdata, cpu_rdata;
  logic          dbg_req, dbg_we, dbg_gnt, dbg_rvalid, dbg_lock;
  logic [AW:0]   dbg_addr;
  logic [DW-1:0] dbg_wdata, dbg_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_wdata, ram_rdata;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .dbg_lock(dbg_lock),
    .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  // Synchronous RAM: data appears one cycle after the address.
  logic [DW-1:0] mem [256];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] <= {8'hD1, 8'(i)};
    forever begin
      @(posedge clk);
      if (ram_we) mem[ram_addr] <= ram_wdata;
      ram_rdata <= mem[ram_addr];
    end
  end

  typedef struct { bit port; logic [DW-1:0] data; int cyc; } exp_t;
  typedef struct {
    bit rst, creq, cwe; logic [AW:0] caddr; logic [DW-1:0] cwd;
    bit dreq, dwe; logic [AW:0] daddr; logic [DW-1:0] dwd; bit lock;
    bit ecg, edg, ewe; logic [AW-1:0] eaddr;
  } vec_t;

  exp_t          sb[$];
  vec_t          tbl[$];
  logic [DW-1:0] model [256];
  logic [DW-1:0] last_rd [2];
  int            n_chk, n_fail, cyc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic grant_seen(input bit p, input logic we, input logic [AW:0] addr,
                            input logic [DW-1:0] wd);
    bit inr; logic [AW-1:0] a; string nm; exp_t e;
    nm  = p ? "dbg" : "cpu";
    inr = !addr[AW];
    a   = addr[AW-1:0];
    chk({nm, "_ram_addr"}, ram_addr, a);
    chk({nm, "_ram_we"}, ram_we, we && inr);
    if (we) begin
      if (inr) begin
        chk({nm, "_ram_wdata"}, ram_wdata, wd);
        model[a] = wd;
      end
    end else begin
      e.port = p;
      e.data = inr ? model[a] : {DW{1'b0}};
      e.cyc  = cyc;
      sb.push_back(e);
    end
  endtask

  task automatic monitor();
    exp_t e; bit due; logic rv; logic [DW-1:0] rd; string nm;
    cyc++;
    if (reset) begin
      sb.delete();
      last_rd[0] = '0;
      last_rd[1] = '0;
      return;
    end
    due = 1'b0;
    if (sb.size() > 0 && sb[0].cyc + 1 == cyc) begin
      e   = sb.pop_front();
      due = 1'b1;
    end
    for (int p = 0; p < 2; p++) begin
      nm = (p == 1) ? "dbg" : "cpu";
      rv = (p == 1) ? dbg_rvalid : cpu_rvalid;
      rd = (p == 1) ? dbg_rdata : cpu_rdata;
      if (due && e.port == 1'(p)) begin
        chk({nm, "_rvalid"}, rv, 1);
        chk({nm, "_rdata"}, rd, e.data);
        last_rd[p] = e.data;
      end else begin
        chk({nm, "_no_rvalid"}, rv, 0);
        chk({nm, "_rdata_hold"}, rd, last_rd[p]);
      end
    end
    chk("gnt_exclusive", cpu_gnt & dbg_gnt, 0);
    if (cpu_gnt) grant_seen(1'b0, cpu_we, cpu_addr, cpu_wdata);
    if (dbg_gnt) grant_seen(1'b1, dbg_we, dbg_addr, dbg_wdata);
    if (!cpu_gnt && !dbg_gnt) chk("ram_we_idle", ram_we, 0);
  endtask

  task automatic sample();
    @(negedge clk);
    monitor();
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reset = 1'b0; dbg_lock = 1'b0;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
  endtask

  task automatic step_idle(input int n);
    repeat (n) begin idle(); sample(); adv(); end
  endtask

  task automatic drive(input vec_t v);
    reset = v.rst;
    cpu_req = v.creq; cpu_we = v.cwe; cpu_addr = v.caddr; cpu_wdata = v.cwd;
    dbg_req = v.dreq; dbg_we = v.dwe; dbg_addr = v.daddr; dbg_wdata = v.dwd;
    dbg_lock = v.lock;
  endtask

  // Counts the unbroken run of dbg grants and reports whether cpu is granted right after it.
  task automatic run_burst(output int n, output bit got_cpu);
    bit started;
    started = 1'b0; n = 0; got_cpu = 1'b0;
    for (int i = 0; i < 40; i++) begin
      sample();
      if (dbg_gnt) begin
        started = 1'b1;
        n++;
      end else if (started) begin
        got_cpu = cpu_gnt;
        adv();
        break;
      end
      adv();
    end
  endtask

  function automatic vec_t V(bit rst, bit creq, bit cwe, logic [AW:0] ca, logic [DW-1:0] cd,
                             bit dreq, bit dwe, logic [AW:0] da, logic [DW-1:0] dd, bit lk,
                             bit ecg, bit edg, bit ewe, logic [AW-1:0] ea);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = ca; v.cwd = cd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = da; v.dwd = dd; v.lock = lk;
    v.ecg = ecg; v.edg = edg; v.ewe = ewe; v.eaddr = ea;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n; bit got;
    n_chk = 0; n_fail = 0; cyc = 0;
    last_rd[0] = '0; last_rd[1] = '0;
    for (int i = 0; i < 256; i++) model[i] = {8'hD1, 8'(i)};
    idle();
    reset = 1'b1;

    //               rst creq cwe caddr   cwdata    dreq dwe daddr   dwdata    lk  cg dg we addr
    tbl.push_back(V(1, 0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 0, 8'h00));
    tbl.push_back(V(1, 1, 0, 9'h005, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 0, 8'h00));
    tbl.push_back(V(0, 1, 0, 9'h005, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  1, 0, 0, 8'h05));
    tbl.push_back(V(0, 0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 0, 8'h05));
    tbl.push_back(V(1, 0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 0, 8'h00));
    tbl.push_back(V(0, 1, 0, 9'h010, 16'h0000, 1, 0, 9'h020, 16'h0000, 0,  1, 0, 0, 8'h10));
    tbl.push_back(V(0, 1, 0, 9'h010, 16'h0000, 1, 0, 9'h020, 16'h0000, 0,  0, 1, 0, 8'h20));
    tbl.push_back(V(0, 1, 0, 9'h010, 16'h0000, 1, 0, 9'h020, 16'h0000, 0,  1, 0, 0, 8'h10));
    tbl.push_back(V(0, 1, 0, 9'h010, 16'h0000, 1, 0, 9'h020, 16'h0000, 0,  0, 1, 0, 8'h20));
    tbl.push_back(V(0, 1, 1, 9'h0AA, 16'hBEEF, 0, 0, 9'h000, 16'h0000, 0,  1, 0, 1, 8'hAA));
    tbl.push_back(V(0, 0, 0, 9'h000, 16'h0000, 1, 0, 9'h0AA, 16'h0000, 0,  0, 1, 0, 8'hAA));
    tbl.push_back(V(0, 1, 0, 9'h100, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  1, 0, 0, 8'h00));
    tbl.push_back(V(0, 1, 1, 9'h1FF, 16'hDEAD, 0, 0, 9'h000, 16'h0000, 0,  1, 0, 0, 8'hFF));
    tbl.push_back(V(0, 1, 0, 9'h0FF, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  1, 0, 0, 8'hFF));
    tbl.push_back(V(0, 1, 1, 9'h031, 16'h6666, 1, 1, 9'h030, 16'h5555, 0,  0, 1, 1, 8'h30));
    tbl.push_back(V(0, 1, 1, 9'h031, 16'h6666, 1, 1, 9'h030, 16'h5555, 0,  1, 0, 1, 8'h31));
    tbl.push_back(V(0, 0, 0, 9'h000, 16'h0000, 1, 0, 9'h030, 16'h0000, 0,  0, 1, 0, 8'h30));
    tbl.push_back(V(0, 0, 0, 9'h000, 16'h0000, 0, 0, 9'h000, 16'h0000, 0,  0, 0, 0, 8'h30));

    adv();
    foreach (tbl[i]) begin
      drive(tbl[i]);
      sample();
      chk($sformatf("v%0d_cpu_gnt", i), cpu_gnt, tbl[i].ecg);
      chk($sformatf("v%0d_dbg_gnt", i), dbg_gnt, tbl[i].edg);
      chk($sformatf("v%0d_ram_we", i), ram_we, tbl[i].ewe);
      chk($sformatf("v%0d_ram_addr", i), ram_addr, tbl[i].eaddr);
      adv();
    end

    // Locked dbg write burst against a continuously requesting cpu.
    idle();
    cpu_req = 1'b1; cpu_addr = 9'h040;
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 9'h014; dbg_wdata = 16'h1234; dbg_lock = 1'b1;
    run_burst(n, got);
    chk("burst_len", n, MB);
    chk("cpu_after_burst", got, 1);
    step_idle(2);
    chk("ram_word_0x14", mem[8'h14], 16'h1234);
    idle(); cpu_req = 1'b1; cpu_addr = 9'h014;
    sample(); chk("rd14_gnt", cpu_gnt, 1); adv();
    step_idle(1);

    // Locked burst paused by dbg_req gaps: the counter must resume where it stopped.
    idle(); dbg_req = 1'b1; dbg_addr = 9'h050; dbg_lock = 1'b1;
    repeat (3) begin sample(); chk("lock_pre_dbg_gnt", dbg_gnt, 1); adv(); end
    dbg_req = 1'b0; cpu_req = 1'b1; cpu_addr = 9'h060;
    repeat (3) begin
      sample();
      chk("lock_gap_cpu_gnt", cpu_gnt, 0);
      chk("lock_gap_dbg_gnt", dbg_gnt, 0);
      adv();
    end
    dbg_req = 1'b1;
    run_burst(n, got);
    chk("burst_resume_len", n, MB - 3);
    chk("cpu_after_resume", got, 1);
    step_idle(2);

    // Dropping dbg_lock ends the burst and lets the cpu back in.
    idle(); dbg_req = 1'b1; dbg_addr = 9'h051; dbg_lock = 1'b1;
    repeat (2) begin sample(); chk("unlock_pre_dbg_gnt", dbg_gnt, 1); adv(); end
    dbg_req = 1'b0; dbg_lock = 1'b0; cpu_req = 1'b1; cpu_addr = 9'h061;
    got = 1'b0;
    for (int i = 0; i < 3 && !got; i++) begin sample(); got = cpu_gnt; adv(); end
    chk("cpu_after_unlock", got, 1);
    step_idle(2);

    // Reset together with a dbg read request.
    idle(); reset = 1'b1; dbg_req = 1'b1; dbg_addr = 9'h005;
    sample();
    chk("rst_dbg_gnt", dbg_gnt, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    adv();
    idle(); sample();
    chk("post_rst_dbg_rvalid", dbg_rvalid, 0);
    chk("post_rst_dbg_rdata", dbg_rdata, 0);
    adv();

    // Reset arriving while a granted dbg read is in flight.
    idle(); dbg_req = 1'b1; dbg_addr = 9'h007;
    sample(); chk("inflight_pre_gnt", dbg_gnt, 1); adv();
    step_idle(1);
    idle(); dbg_req = 1'b1; dbg_addr = 9'h005;
    sample(); chk("inflight_gnt", dbg_gnt, 1); adv();
    idle(); reset = 1'b1;
    sample(); chk("inflight_rst_rvalid", dbg_rvalid, 0); adv();
    idle(); sample();
    chk("inflight_dbg_rvalid", dbg_rvalid, 0);
    chk("inflight_dbg_rdata", dbg_rdata, 0);
    chk("inflight_cpu_rvalid", cpu_rvalid, 0);
    chk("inflight_cpu_rdata", cpu_rdata, 0);
    chk("inflight_gnts", {cpu_gnt, dbg_gnt}, 0);
    chk("inflight_ram_we", ram_we, 0);
    chk("inflight_ram_addr", ram_addr, 0);
    adv();
    step_idle(3);

    chk("sb_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
